sram_mp: RTL

- Synchronous, parametrised multi-port data memory for the superscalar datapath; next generation of the three-port unclocked SRAM model.
- Replaces the address-search behavioural model with a directly indexed word array.
- Adds per-port byte enables, a registered read latency, per-word valid tracking, address error flagging and write-collision arbitration.
- Instantiated once per memory (IMEM/DMEM); one port per issue slot.

---
 rtl/sram_mp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_mp.sv
// sram_mp: multi-port synchronous data memory, byte enables, 1-cycle reads.
// Define SRAM_BYPASS_EN for write-first reads; read-first otherwise.
module sram_mp #(
  parameter int NPORTS = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs,
  input  logic [NPORTS-1:0]            we,
  input  logic [NPORTS-1:0]            oe,
  input  logic [NPORTS*ADDR_W-1:0]     addr,
  input  logic [NPORTS*DATA_W-1:0]     din,
  input  logic [NPORTS*(DATA_W/8)-1:0] be,
  output logic [NPORTS*DATA_W-1:0]     dout,
  output logic [NPORTS-1:0]            rvalid,
  output logic [NPORTS-1:0]            err,
  output logic                         wcollide
);

  localparam int BW  = DATA_W / 8;
  localparam int OFS = $clog2(BW);
  localparam int IW  = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] ONES = '1;
  // set bits mark misaligned offset bits and out-of-range high bits
  localparam logic [ADDR_W-1:0] BAD_MASK =
    ~(ONES << OFS) | (ONES << (OFS + IW));

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic [IW-1:0]     idx [NPORTS];
  logic [NPORTS-1:0] bad;
  logic [NPORTS-1:0] act;
  logic [NPORTS-1:0] wr_en;
  logic [NPORTS-1:0] rd_en;
  logic [DATA_W-1:0] rd_word [NPORTS];
  logic              coll;

  always_comb begin
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int p = 0; p < NPORTS; p++) begin
      a        = addr[p*ADDR_W +: ADDR_W];
      idx[p]   = a[OFS +: IW];
      bad[p]   = |(a & BAD_MASK);
      act[p]   = cs & (we[p] | oe[p]);
      wr_en[p] = cs & we[p] & ~bad[p] & (|be[p*BW +: BW]);
      rd_en[p] = cs & oe[p] & ~bad[p];
    end
  end

  always_comb begin
    logic [DATA_W-1:0] w;
    logic              v;
    w = '0;
    v = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      w = mem[idx[p]];
      v = vld[idx[p]];
`ifdef SRAM_BYPASS_EN
      // replay all same-cycle writes in port order: highest port wins
      for (int q = 0; q < NPORTS; q++) begin
        if (wr_en[q] && idx[q] == idx[p]) begin
          v = 1'b1;
          for (int b = 0; b < BW; b++) begin
            if (be[q*BW + b])
              w[b*8 +: 8] = din[q*DATA_W + b*8 +: 8];
          end
        end
      end
`endif
      rd_word[p] = v ? w : '0;
    end
  end

  always_comb begin
    coll = 1'b0;
    for (int q = 0; q < NPORTS; q++) begin
      for (int r = q + 1; r < NPORTS; r++) begin
        if (wr_en[q] && wr_en[r] && idx[q] == idx[r])
          coll = 1'b1;
      end
    end
  end

  // array is not reset; later ports override earlier ones byte by byte
  always_ff @(posedge clk) begin
    for (int q = 0; q < NPORTS; q++) begin
      for (int b = 0; b < BW; b++) begin
        if (wr_en[q] && be[q*BW + b])
          mem[idx[q]][b*8 +: 8] <= din[q*DATA_W + b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      dout     <= '0;
      rvalid   <= '0;
      err      <= '0;
      wcollide <= 1'b0;
    end else begin
      wcollide <= coll;
      for (int p = 0; p < NPORTS; p++) begin
        rvalid[p] <= cs & oe[p];
        err[p]    <= act[p] & bad[p];
        if (rd_en[p])
          dout[p*DATA_W +: DATA_W] <= rd_word[p];
        else if (cs && oe[p])
          dout[p*DATA_W +: DATA_W] <= '0;
        if (wr_en[p])
          vld[idx[p]] <= 1'b1;
      end
    end
  end

endmodule
